// File: rtl/turn_controller.sv
// Turn sequencer for a two-player board game: cursor navigation, move issue to the
// addressed square, and player alternation. Optional idle-turn timeout under TURN_TIMEOUT_EN.
module turn_controller #(
  parameter int NUM_SQUARES    = 9,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_next,
  input  logic                     btn_confirm,
  input  logic [2*NUM_SQUARES-1:0] board,
  input  logic                     game_over,
  output logic [3:0]               code,
  output logic                     sel,
  output logic                     pl,
  output logic [3:0]               cursor,
  output logic                     reject,
  output logic                     timeout
);

  if (NUM_SQUARES < 2 || NUM_SQUARES > 15) begin : g_bad_squares
    $error("turn_controller: NUM_SQUARES must be 2..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("turn_controller: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] NO_SQUARE = 4'hF;
  localparam logic [3:0] LAST_SQ   = 4'(NUM_SQUARES - 1);

  state_t     state_q, state_d;
  logic [3:0] cursor_q, cursor_d;
  logic [3:0] code_q, code_d;
  logic       sel_q, sel_d;
  logic       pl_q, pl_d;
  logic       reject_q, reject_d;
  logic       timeout_q, timeout_d;
  logic       occupied;
  logic       expire;

  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (cursor_q == 4'(i)) occupied = |board[2*i +: 2];
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          idle_quiet;

  // Only a button-free IDLE cycle ages the turn; everything else restarts it.
  assign idle_quiet = (state_q == IDLE) && !btn_next && !btn_confirm && !game_over;
  assign expire     = idle_quiet && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (idle_quiet && !expire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cursor_q  <= '0;
      code_q    <= NO_SQUARE;
      sel_q     <= 1'b0;
      pl_q      <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      code_q    <= code_d;
      sel_q     <= sel_d;
      pl_q      <= pl_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (game_over)                     state_d = DONE;
        else if (btn_confirm && !occupied) state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = game_over ? DONE : IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so sel/code are valid during ISSUE itself.
  always_comb begin
    cursor_d  = cursor_q;
    pl_d      = pl_q;
    reject_d  = 1'b0;
    timeout_d = expire;
    sel_d     = (state_d == ISSUE);
    code_d    = sel_d ? cursor_q : NO_SQUARE;
    if (state_q == IDLE && !game_over) begin
      if (btn_confirm)   reject_d = occupied;
      else if (btn_next) cursor_d = (cursor_q == LAST_SQ) ? 4'd0 : cursor_q + 4'd1;
    end
    if ((state_q == WAIT && state_d == IDLE) || expire) pl_d = ~pl_q;
  end

  assign code    = code_q;
  assign sel     = sel_q;
  assign pl      = pl_q;
  assign cursor  = cursor_q;
  assign reject  = reject_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: drivers feed button pulses, a negedge monitor
// pops expected sel/reject transactions from queues.
module tb_turn_controller;

  localparam int N  = 9;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           btn_next = 1'b0;
  logic           btn_confirm = 1'b0;
  logic [2*N-1:0] board = '0;
  logic           game_over = 1'b0;
  logic [3:0]     code;
  logic           sel;
  logic           pl;
  logic [3:0]     cursor;
  logic           reject;
  logic           timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected move transactions {code, pl} and expected reject cursor positions.
  logic [4:0] exp_q[$];
  logic [3:0] rej_q[$];

  turn_controller #(.NUM_SQUARES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_confirm(btn_confirm),
    .board(board), .game_over(game_over), .code(code), .sel(sel), .pl(pl),
    .cursor(cursor), .reject(reject), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; btn_next = 1'b0; btn_confirm = 1'b0; game_over = 1'b0; board = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic nxt, input logic cfm);
    @(negedge clk);
    btn_next = nxt; btn_confirm = cfm;
    @(negedge clk);
    btn_next = 1'b0; btn_confirm = 1'b0;
  endtask

  // Monitor: every sel or reject cycle must match the head of its queue.
  always @(negedge clk) begin
    if (sel) begin
      if (exp_q.size() == 0) check("sel_unexpected", {code, pl}, 5'h1F);
      else check("sel_txn", {code, pl}, exp_q.pop_front());
    end
    if (reject) begin
      if (rej_q.size() == 0) check("reject_unexpected", cursor, 4'hE);
      else check("reject_txn", cursor, rej_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset_dut();
    check("rst_cursor", cursor, 0);
    check("rst_pl", pl, 0);
    check("rst_sel", sel, 0);
    check("rst_code", code, 4'hF);
    check("rst_reject", reject, 0);
    check("rst_timeout", timeout, 0);

    // Basic move: sel one cycle after confirm, pl toggles after WAIT
    exp_q.push_back({4'd0, 1'b0});
    pulse(1'b0, 1'b1);
    @(negedge clk);
    check("move_code_after", code, 4'hF);
    check("move_pl_hold", pl, 0);
    @(negedge clk);
    check("move_pl_toggle", pl, 1);

    // Cursor walk and wrap
    repeat (8) pulse(1'b1, 1'b0);
    check("cursor_8", cursor, 8);
    pulse(1'b1, 1'b0);
    check("cursor_wrap", cursor, 0);

    // Occupied square rejected
    repeat (4) pulse(1'b1, 1'b0);
    check("cursor_4", cursor, 4);
    board = 18'h00100;
    rej_q.push_back(4'd4);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    check("reject_width", reject, 0);
    @(negedge clk);
    check("reject_pl", pl, 1);
    check("reject_cursor", cursor, 4);

    // Simultaneous next+confirm: confirm wins, cursor stays
    reset_dut();
    repeat (2) pulse(1'b1, 1'b0);
    check("cursor_2", cursor, 2);
    exp_q.push_back({4'd2, 1'b0});
    pulse(1'b1, 1'b1);
    check("both_cursor", cursor, 2);
    repeat (2) @(negedge clk);
    check("both_pl", pl, 1);
    check("both_cursor_after", cursor, 2);

    // game_over during ISSUE: full sel pulse, then DONE without toggle
    reset_dut();
    exp_q.push_back({4'd0, 1'b0});
    @(negedge clk); btn_confirm = 1'b1;
    @(negedge clk); btn_confirm = 1'b0; game_over = 1'b1;
    @(negedge clk);
    check("go_sel_drop", sel, 0);
    @(negedge clk);
    game_over = 1'b0;
    check("go_pl_hold", pl, 0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("done_cursor", cursor, 0);
    check("done_pl", pl, 0);
    check("done_code", code, 4'hF);
    reset_dut();
    pulse(1'b1, 1'b0);
    check("done_exit_rst", cursor, 1);

    // game_over in IDLE freezes the controller
    @(negedge clk); game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
    pulse(1'b1, 1'b0);
    check("idle_go_cursor", cursor, 1);

    // Reset during ISSUE drops sel and suppresses the toggle
    reset_dut();
    exp_q.push_back({4'd0, 1'b0});
    pulse(1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_issue_sel", sel, 0);
    check("rst_issue_code", code, 4'hF);
    repeat (2) @(negedge clk);
    check("rst_issue_pl", pl, 0);
    pulse(1'b1, 1'b0);
    check("rst_issue_idle", cursor, 1);

`ifdef TURN_TIMEOUT_EN
    begin
      int n = 0;
      bit found = 0;
      reset_dut();
      for (int i = 1; i <= 40 && !found; i++) begin
        @(negedge clk);
        if (timeout) begin found = 1; n = i; end
      end
      check("timeout_cycle", n, 16);
      check("timeout_pl", pl, 1);
      n = 0; found = 0;
      for (int i = 1; i <= 60 && !found; i++) begin
        @(negedge clk);
        if (timeout) begin found = 1; n = i; end
        btn_next = (i == 9);
      end
      btn_next = 1'b0;
      check("timeout_restart", n, 26);
      check("timeout_pl2", pl, 0);
      check("timeout_cursor", cursor, 1);
    end
`else
    begin
      int seen = 0;
      reset_dut();
      repeat (40) begin
        @(negedge clk);
        if (timeout) seen++;
      end
      check("timeout_tied", seen, 0);
      check("idle_pl_steady", pl, 0);
    end
`endif

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("rej_q_drained", rej_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
